countdown_timer: RTL and testbench
==================================

# countdown_timer

Down-counting HH:MM:SS timer for the clock design, the borrow-driven counterpart of the up-counting time-keeping chain. It accepts a preset time, decrements once per second using its own prescaler, and chains seconds, minutes and hours through borrows instead of carries. On reaching 00:00:00 it emits a one-cycle `expired` pulse for the alarm/display logic.

## Interface
- `TICK_DIV`, 1000: clock cycles per one-second tick; must be ≥2.
- `HOUR_MAX`, 23: largest loadable hour value.
- `clock` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `load` in 1: one-cycle pulse; captures `load_hh/mm/ss`.
- `load_hh` in 5: preset hours.
- `load_mm` in 6: preset minutes.
- `load_ss` in 6: preset seconds.
- `start` in 1: one-cycle pulse; begin or resume counting.
- `stop` in 1: one-cycle pulse; pause counting.
- `hh` out 5: current hours.
- `mm` out 6: current minutes.
- `ss` out 6: current seconds.
- `running` out 1: high in RUN.
- `expired` out 1: one-cycle pulse when the count reaches zero.

## Operation
- States: IDLE, RUN, PAUSE, EXPIRED. Reset: IDLE, prescaler 0, `hh`=`mm`=`ss`=0, `running`=0, `expired`=0, reload register 0.
- Load: captured in any state. `load_mm` and `load_ss` above 59 clamp to 59; `load_hh` above HOUR_MAX clamps to HOUR_MAX. The clamped value is written to the outputs and the reload register. State goes to IDLE and the prescaler clears.
- IDLE→RUN on `start` if the value is nonzero. A `start` at 00:00:00 is ignored. The prescaler clears on entry from IDLE.
- RUN→PAUSE on `stop`, with the prescaler held. PAUSE→RUN on `start`, and the prescaler resumes from its held value.
- In RUN the prescaler counts 0..TICK_DIV-1. The tick fires on the cycle the prescaler equals TICK_DIV-1, and the prescaler wraps to 0.
- Tick arithmetic uses borrow chaining:
  - `ss`>0: `ss`-1.
  - Otherwise, if `mm`>0: `ss`=59, `mm`-1.
  - Otherwise, if `hh`>0: `ss`=59, `mm`=59, `hh`-1.
- A tick that produces 00:00:00 moves RUN→EXPIRED and asserts `expired` for exactly one cycle, registered on the same edge the outputs reach zero.
- EXPIRED holds 00:00:00. `start` is ignored there; only `load` leaves EXPIRED.
- Priority for simultaneous events: `load` > `stop` > `start` > tick. When `stop` and `start` arrive together, `stop` wins. A tick coinciding with `stop` is discarded.
- Outputs never leave their range. No wrap below zero.

## Timing
- `load` → new `hh/mm/ss` visible one cycle after the load edge.
- `start` → `running` high the next cycle. The first tick occurs TICK_DIV cycles after `running` rises.
- `stop` → `running` low the next cycle.
- Preset N seconds with no pause → `expired` asserts N×TICK_DIV cycles after `running` rises.
- Reset mid-operation clears everything immediately (asynchronous). No pulse survives reset.

## Configuration
- `COUNTDOWN_AUTO_RELOAD_EN` defined:
  - On reaching zero, `expired` still pulses for one cycle.
  - On that same edge the outputs take the reload register value and the state stays RUN, giving a periodic timer.
  - If the reload register is zero, the block enters EXPIRED instead.
- `COUNTDOWN_AUTO_RELOAD_EN` undefined: behaviour is exactly as in Operation. The reload register is still present, but it does not affect the count.

## Structure
- Shared package holds:
  - state enum (IDLE, RUN, PAUSE, EXPIRED);
  - constants SEC_MAX=59 and MIN_MAX=59;
  - width constants HH_W=5 and MS_W=6.
- One sub-module is natural: `down_digit_counter`, parameterised by width and max value.
  - Inputs: `dec_req`, `load`, `load_val`.
  - Outputs: value, `borrow`, plus `is_zero` (combinational).
  - On `dec_req` at zero it reloads max and asserts `borrow`.
  - Three instances are chained; the top-level FSM, prescaler and expiry detection live in `countdown_timer`.

## Test plan
Bench uses TICK_DIV=4.
1. Load 00:00:03, `start` → `ss` steps 3,2,1,0 at 4-cycle intervals; `expired` is a single one-cycle pulse 12 cycles after `running` rises; `running`=0 afterwards.
2. Load 01:00:00, `start`, one tick → 00:59:59; next tick → 00:59:58.
3. Load 00:00:10, `start`, `stop` two cycles before the 2nd tick, wait 20 cycles (`ss` holds 9), `start` → `ss`=8 exactly two cycles later.
4. `load` with `load_mm`=63, `load_ss`=60, `load_hh`=30 → reads 23:59:59. `start` at 00:00:00 → `running` stays 0.
5. Same cycle: `load`+`start` → loaded value, IDLE. Same cycle: `start`+`stop` in PAUSE → stays PAUSE. Assert `reset` mid-RUN → all outputs 0 at once.
6. With `COUNTDOWN_AUTO_RELOAD_EN`: load 00:00:02, `start` → `expired` pulses every 8 cycles, value returns to 00:00:02, `running` stays 1.

Source files
------------

// File: rtl/countdown_timer_pkg.sv
// Shared types and constants for the HH:MM:SS countdown timer.
package countdown_timer_pkg;

   typedef enum logic [1:0] {StIdle, StRun, StPause, StExpired} state_e;

   localparam int unsigned SEC_MAX = 59;
   localparam int unsigned MIN_MAX = 59;
   localparam int unsigned HH_W    = 5;
   localparam int unsigned MS_W    = 6;

   function automatic logic [MS_W-1:0] clamp_ms(input logic [MS_W-1:0] v,
                                                input int unsigned max_val);
      return (32'(v) > max_val) ? MS_W'(max_val) : v;
   endfunction

   function automatic logic [HH_W-1:0] clamp_hh(input logic [HH_W-1:0] v,
                                                input int unsigned max_val);
      return (32'(v) > max_val) ? HH_W'(max_val) : v;
   endfunction

endpackage

// File: rtl/countdown_timer_down_digit_counter.sv
// One down-counting time digit group; wraps to its max and borrows when decremented at zero.
module down_digit_counter #(
   parameter int unsigned Width  = 6,
   parameter int unsigned MaxVal = 59
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             dec_req,
   input  logic             load,
   input  logic [Width-1:0] load_val,
   output logic [Width-1:0] value,
   output logic             borrow,
   output logic             is_zero
);

   localparam logic [Width-1:0] MaxV = Width'(MaxVal);

   logic [Width-1:0] value_q, value_d;

   assign is_zero = (value_q == '0);
   // Borrow is independent of load so the top can use it to override a load without a loop.
   assign borrow  = dec_req & is_zero;
   assign value   = value_q;

   always_comb begin
      value_d = value_q;
      if (load) begin
         value_d = load_val;
      end else if (dec_req) begin
         value_d = is_zero ? MaxV : value_q - Width'(1);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         value_q <= '0;
      end else begin
         value_q <= value_d;
      end
   end

endmodule

// File: rtl/countdown_timer.sv
// HH:MM:SS down-counting timer with prescaler, pause/resume and a one-cycle expiry pulse.
// Build option: define COUNTDOWN_AUTO_RELOAD_EN to reload the preset on expiry (periodic mode).
module countdown_timer
   import countdown_timer_pkg::*;
#(
   parameter int unsigned TICK_DIV = 1000,
   parameter int unsigned HOUR_MAX = 23
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            load,
   input  logic [HH_W-1:0] load_hh,
   input  logic [MS_W-1:0] load_mm,
   input  logic [MS_W-1:0] load_ss,
   input  logic            start,
   input  logic            stop,
   output logic [HH_W-1:0] hh,
   output logic [MS_W-1:0] mm,
   output logic [MS_W-1:0] ss,
   output logic            running,
   output logic            expired
);

   localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PrescLast = PW'(TICK_DIV - 1);

   state_e state_q, state_d;
   logic [PW-1:0] presc_q, presc_d;
   logic expired_q, expired_d;
   logic [HH_W-1:0] rl_hh_q, rl_hh_d;
   logic [MS_W-1:0] rl_mm_q, rl_mm_d, rl_ss_q, rl_ss_d;

   logic [HH_W-1:0] ld_hh_c, cnt_hh_val;
   logic [MS_W-1:0] ld_mm_c, ld_ss_c, cnt_mm_val, cnt_ss_val;
   logic tick, reload_evt, cnt_load;
   logic ss_borrow, mm_borrow, hh_borrow;
   logic ss_zero, mm_zero, hh_zero, all_zero, tick_to_zero;

   assign ld_hh_c = clamp_hh(load_hh, HOUR_MAX);
   assign ld_mm_c = clamp_ms(load_mm, MIN_MAX);
   assign ld_ss_c = clamp_ms(load_ss, SEC_MAX);

   assign all_zero     = hh_zero & mm_zero & ss_zero;
   assign tick_to_zero = hh_zero & mm_zero & (ss == MS_W'(1));

   always_comb begin
      state_d    = state_q;
      presc_d    = presc_q;
      expired_d  = 1'b0;
      tick       = 1'b0;
      reload_evt = 1'b0;
      rl_hh_d    = rl_hh_q;
      rl_mm_d    = rl_mm_q;
      rl_ss_d    = rl_ss_q;
      if (load) begin
         rl_hh_d = ld_hh_c;
         rl_mm_d = ld_mm_c;
         rl_ss_d = ld_ss_c;
         state_d = StIdle;
         presc_d = '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start && !all_zero) begin
                  state_d = StRun;
                  presc_d = '0;
               end
            end
            StRun: begin
               // Stopping holds the prescaler; a tick landing on the stop edge is dropped.
               if (stop) begin
                  state_d = StPause;
               end else if (presc_q == PrescLast) begin
                  tick    = 1'b1;
                  presc_d = '0;
                  if (tick_to_zero) begin
                     expired_d = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                     if ((rl_hh_q != '0) || (rl_mm_q != '0) || (rl_ss_q != '0)) begin
                        reload_evt = 1'b1;
                     end else begin
                        state_d = StExpired;
                     end
`else
                     state_d = StExpired;
`endif
                  end
               end else begin
                  presc_d = presc_q + PW'(1);
               end
            end
            StPause: begin
               if (!stop && start) begin
                  state_d = StRun;
               end
            end
            StExpired: begin
               state_d = StExpired;
            end
            default: state_d = StIdle;
         endcase
      end
   end

   // A borrow out of the hours digit would wrap upward, so it pins the count to zero instead.
   assign cnt_load = load | reload_evt | hh_borrow;

   always_comb begin
      cnt_hh_val = '0;
      cnt_mm_val = '0;
      cnt_ss_val = '0;
      if (load) begin
         cnt_hh_val = ld_hh_c;
         cnt_mm_val = ld_mm_c;
         cnt_ss_val = ld_ss_c;
      end else if (reload_evt) begin
         cnt_hh_val = rl_hh_q;
         cnt_mm_val = rl_mm_q;
         cnt_ss_val = rl_ss_q;
      end
   end

   down_digit_counter #(.Width(MS_W), .MaxVal(SEC_MAX)) u_ss (
      .clock    (clock),
      .reset    (reset),
      .dec_req  (tick),
      .load     (cnt_load),
      .load_val (cnt_ss_val),
      .value    (ss),
      .borrow   (ss_borrow),
      .is_zero  (ss_zero)
   );

   down_digit_counter #(.Width(MS_W), .MaxVal(MIN_MAX)) u_mm (
      .clock    (clock),
      .reset    (reset),
      .dec_req  (ss_borrow),
      .load     (cnt_load),
      .load_val (cnt_mm_val),
      .value    (mm),
      .borrow   (mm_borrow),
      .is_zero  (mm_zero)
   );

   down_digit_counter #(.Width(HH_W), .MaxVal(HOUR_MAX)) u_hh (
      .clock    (clock),
      .reset    (reset),
      .dec_req  (mm_borrow),
      .load     (cnt_load),
      .load_val (cnt_hh_val),
      .value    (hh),
      .borrow   (hh_borrow),
      .is_zero  (hh_zero)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= StIdle;
         presc_q   <= '0;
         expired_q <= 1'b0;
         rl_hh_q   <= '0;
         rl_mm_q   <= '0;
         rl_ss_q   <= '0;
      end else begin
         state_q   <= state_d;
         presc_q   <= presc_d;
         expired_q <= expired_d;
         rl_hh_q   <= rl_hh_d;
         rl_mm_q   <= rl_mm_d;
         rl_ss_q   <= rl_ss_d;
      end
   end

   assign running = (state_q == StRun);
   assign expired = expired_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer with TICK_DIV=4.
module tb_countdown_timer;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       load = 1'b0, start = 1'b0, stop = 1'b0;
   logic [4:0] load_hh = '0;
   logic [5:0] load_mm = '0, load_ss = '0;
   logic [4:0] hh;
   logic [5:0] mm, ss;
   logic       running, expired;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   always #5 clock = ~clock;

   countdown_timer #(.TICK_DIV(4), .HOUR_MAX(23)) dut (
      .clock   (clock),
      .reset   (reset),
      .load    (load),
      .load_hh (load_hh),
      .load_mm (load_mm),
      .load_ss (load_ss),
      .start   (start),
      .stop    (stop),
      .hh      (hh),
      .mm      (mm),
      .ss      (ss),
      .running (running),
      .expired (expired)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Each step ends 1 time unit after a rising edge, away from the sampling edge.
   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic do_load(input int h, input int m, input int s);
      load_hh = 5'(h);
      load_mm = 6'(m);
      load_ss = 6'(s);
      load = 1'b1;
      step(1);
      load = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step(1);
      start = 1'b0;
   endtask

   task automatic pulse_stop();
      stop = 1'b1;
      step(1);
      stop = 1'b0;
   endtask

   task automatic check_time(input string tag, input int h, input int m, input int s);
      check({tag, "_hh"}, 32'(hh), 32'(h));
      check({tag, "_mm"}, 32'(mm), 32'(m));
      check({tag, "_ss"}, 32'(ss), 32'(s));
   endtask

   initial begin
      step(2);
      check_time("rst", 0, 0, 0);
      check("rst_running", 32'(running), 0);
      check("rst_expired", 32'(expired), 0);
      reset = 1'b1;
      step(1);

      // 00:00:03 counting down to expiry
      do_load(0, 0, 3);
      check("t1_load_ss", 32'(ss), 3);
      pulse_start();
      check("t1_running", 32'(running), 1);
      step(3);
      check("t1_ss_before_tick", 32'(ss), 3);
      step(1);
      check("t1_ss_tick1", 32'(ss), 2);
      step(4);
      check("t1_ss_tick2", 32'(ss), 1);
      step(3);
      check("t1_exp_early", 32'(expired), 0);
      step(1);
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      check("t1_reload_ss", 32'(ss), 3);
      check("t1_exp_pulse", 32'(expired), 1);
      check("t1_run_after", 32'(running), 1);
`else
      check("t1_ss_zero", 32'(ss), 0);
      check("t1_exp_pulse", 32'(expired), 1);
      check("t1_run_after", 32'(running), 0);
      step(1);
      check("t1_exp_one_cycle", 32'(expired), 0);
      pulse_start();
      check("t1_start_in_expired", 32'(running), 0);
      check("t1_hold_zero", 32'(ss), 0);
`endif

      // 01:00:00 borrows through minutes and seconds
      do_load(1, 0, 0);
      pulse_start();
      step(4);
      check_time("t2_tick1", 0, 59, 59);
      step(4);
      check_time("t2_tick2", 0, 59, 58);
      pulse_stop();
      check("t2_stopped", 32'(running), 0);

      // Pause with held prescaler, then resume
      do_load(0, 0, 10);
      pulse_start();
      step(4);
      check("t3_ss_tick1", 32'(ss), 9);
      step(2);
      pulse_stop();
      check("t3_paused", 32'(running), 0);
      step(20);
      check("t3_hold_ss", 32'(ss), 9);
      pulse_start();
      check("t3_resumed", 32'(running), 1);
      step(1);
      check("t3_ss_not_yet", 32'(ss), 9);
      step(1);
      check("t3_ss_tick2", 32'(ss), 8);

      // Clamping and start at zero
      do_load(30, 63, 60);
      check_time("t4_clamp", 23, 59, 59);
      do_load(0, 0, 0);
      pulse_start();
      check("t4_zero_start", 32'(running), 0);

      // Simultaneous events and asynchronous reset
      load_hh = 5'd1;
      load_mm = 6'd2;
      load_ss = 6'd5;
      load = 1'b1;
      start = 1'b1;
      step(1);
      load = 1'b0;
      start = 1'b0;
      check_time("t5_load_start", 1, 2, 5);
      check("t5_load_wins", 32'(running), 0);
      pulse_start();
      pulse_stop();
      start = 1'b1;
      stop = 1'b1;
      step(1);
      start = 1'b0;
      stop = 1'b0;
      check("t5_stop_wins", 32'(running), 0);
      step(3);
      check("t5_pause_hold", 32'(ss), 5);
      pulse_start();
      step(2);
      #1;
      reset = 1'b0;
      #1;
      check_time("t5_async_rst", 0, 0, 0);
      check("t5_rst_running", 32'(running), 0);
      check("t5_rst_expired", 32'(expired), 0);
      #1;
      reset = 1'b1;
      step(2);
      check("t5_idle_after_rst", 32'(running), 0);

`ifdef COUNTDOWN_AUTO_RELOAD_EN
      // Periodic mode: 2 s period, expiry every 8 cycles
      do_load(0, 0, 2);
      pulse_start();
      step(4);
      check("t6_ss_tick1", 32'(ss), 1);
      step(4);
      check("t6_reload1_ss", 32'(ss), 2);
      check("t6_exp1", 32'(expired), 1);
      check("t6_run1", 32'(running), 1);
      step(1);
      check("t6_exp1_drop", 32'(expired), 0);
      step(7);
      check("t6_exp2", 32'(expired), 1);
      check("t6_reload2_ss", 32'(ss), 2);
      check("t6_run2", 32'(running), 1);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
